multicore_pc_stack_bank: RTL



---
 rtl/multicore_pc_stack_bank.sv | 124 ++++++++++++
 1 files changed

// File: rtl/multicore_pc_stack_bank.sv
// NUM_CORES independent program counters, each with a private hardware return stack.
// Optional PC_HALT_EN adds a per-core halt input that freezes that core completely.
module multicore_pc_stack_bank #(
  parameter int NUM_CORES    = 4,
  parameter int ADDR_W       = 16,
  parameter int STACK_DEPTH  = 8,
  parameter int START_BASE   = 0,
  parameter int START_STRIDE = 3
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic [NUM_CORES-1:0]        jump,
  input  logic [NUM_CORES-1:0]        call,
  input  logic [NUM_CORES-1:0]        ret,
`ifdef PC_HALT_EN
  input  logic [NUM_CORES-1:0]        halt,
`endif
  input  logic [NUM_CORES*ADDR_W-1:0] target_addr,
  output logic [NUM_CORES*ADDR_W-1:0] pc_out,
  output logic [NUM_CORES*ADDR_W-1:0] stack_top,
  output logic [NUM_CORES-1:0]        stack_empty,
  output logic [NUM_CORES-1:0]        stack_full,
  output logic [NUM_CORES-1:0]        stack_ovf,
  output logic [NUM_CORES-1:0]        stack_unf
);

  localparam int IDX_W = $clog2(STACK_DEPTH);
  localparam int SP_W  = IDX_W + 1;
  localparam logic [SP_W-1:0] SP_FULL = SP_W'(STACK_DEPTH);

  genvar gi;
  generate
    for (gi = 0; gi < NUM_CORES; gi++) begin : g_core
      localparam logic [ADDR_W-1:0] START_PC = ADDR_W'(START_BASE + gi * START_STRIDE);

      logic [ADDR_W-1:0] r_pc;
      logic [ADDR_W-1:0] r_top;
      logic [SP_W-1:0]   r_sp;
      logic              r_ovf;
      logic              r_unf;
      logic [ADDR_W-1:0] r_stack [STACK_DEPTH];

      logic              w_run;
      logic              w_empty;
      logic              w_full;
      logic              w_do_ret;
      logic              w_do_call;
      logic              w_do_jump;
      logic              w_push;
      logic [ADDR_W-1:0] w_tgt;
      logic [ADDR_W-1:0] w_pc_inc;
      logic [ADDR_W-1:0] w_below;
      logic [IDX_W-1:0]  w_wr_idx;
      logic [IDX_W-1:0]  w_below_idx;

`ifdef PC_HALT_EN
      assign w_run = ~halt[gi];
`else
      assign w_run = 1'b1;
`endif

      assign w_tgt     = target_addr[gi*ADDR_W +: ADDR_W];
      assign w_pc_inc  = r_pc + ADDR_W'(1);
      assign w_empty   = (r_sp == '0);
      assign w_full    = (r_sp == SP_FULL);

      // ret > call > jump > increment; losing strobes have no side effect
      assign w_do_ret  = w_run & ret[gi];
      assign w_do_call = w_run & ~ret[gi] & call[gi];
      assign w_do_jump = w_run & ~ret[gi] & ~call[gi] & jump[gi];
      assign w_push    = w_do_call & ~w_full & ~reset;

      assign w_wr_idx    = r_sp[IDX_W-1:0];
      assign w_below_idx = IDX_W'(r_sp - SP_W'(2));
      // Entry that becomes the new top after a pop; zero once the stack drains
      assign w_below     = (r_sp >= SP_W'(2)) ? r_stack[w_below_idx] : '0;

      always_ff @(posedge clk) begin
        if (w_push) begin
          r_stack[w_wr_idx] <= w_pc_inc;
        end
      end

      always_ff @(posedge clk) begin
        if (reset) begin
          r_pc  <= START_PC;
          r_sp  <= '0;
          r_top <= '0;
          r_ovf <= 1'b0;
          r_unf <= 1'b0;
        end else if (w_do_ret) begin
          if (w_empty) begin
            r_pc  <= w_pc_inc;
            r_unf <= 1'b1;
          end else begin
            r_pc  <= r_top;
            r_sp  <= r_sp - SP_W'(1);
            r_top <= w_below;
          end
        end else if (w_do_call) begin
          r_pc <= w_tgt;
          if (w_full) begin
            r_ovf <= 1'b1;
          end else begin
            r_sp  <= r_sp + SP_W'(1);
            r_top <= w_pc_inc;
          end
        end else if (w_do_jump) begin
          r_pc <= w_tgt;
        end else if (w_run) begin
          r_pc <= w_pc_inc;
        end
      end

      assign pc_out[gi*ADDR_W +: ADDR_W]    = r_pc;
      assign stack_top[gi*ADDR_W +: ADDR_W] = r_top;
      assign stack_empty[gi]                = w_empty;
      assign stack_full[gi]                 = w_full;
      assign stack_ovf[gi]                  = r_ovf;
      assign stack_unf[gi]                  = r_unf;
    end
  endgenerate

endmodule
